// File: rtl/handshake_arb.sv
// Round-robin handshake arbiter with burst locking.
// N requesters compete for one output register slice; a requester that wins
// with last=0 keeps the grant until it delivers a beat with last=1.
module handshake_arb #(
    parameter int N  = 4,
    parameter int DW = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N-1:0]           req_valid_i,
    input  logic [N*DW-1:0]        req_data_i,
    input  logic [N-1:0]           req_last_i,
    output logic [N-1:0]           req_ready_o,
    output logic                   valid_o,
    output logic [DW-1:0]          data_o,
    output logic                   last_o,
    output logic [$clog2(N)-1:0]   src_o,
    input  logic                   ready_i,
    output logic                   busy_o
);

    localparam int LW = $clog2(N);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state;
    logic [LW-1:0] ptr;
    logic [LW-1:0] owner;
    logic          full;

    logic          wr_en;
    logic [LW-1:0] g;
    logic          grant_ok;
    logic [LW-1:0] idx;
    logic          xfer_in;
    logic [DW-1:0] beat_data;
    logic          beat_last;

    assign wr_en   = ~full | ready_i;
    assign valid_o = full;
    assign busy_o  = (state == LOCK);

    // Pick the granted requester: the owner while locked, otherwise the first
    // valid requester at or after ptr. Scanning offsets from the far end down
    // lets the nearest valid requester overwrite the others.
    always_comb begin
        g        = owner;
        grant_ok = 1'b0;
        idx      = '0;
        if (state == LOCK) begin
            g        = owner;
            grant_ok = 1'b1;
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                idx = ptr + LW'(i);
                if (req_valid_i[idx]) begin
                    g        = idx;
                    grant_ok = 1'b1;
                end
            end
        end
    end

    // Only the granted requester ever sees ready, and only when the slice can accept.
    always_comb begin
        req_ready_o = '0;
        if (grant_ok) begin
            req_ready_o[g] = wr_en;
        end
    end

    assign xfer_in   = req_valid_i[g] & req_ready_o[g];
    assign beat_data = req_data_i[int'(g)*DW +: DW];
    assign beat_last = req_last_i[g];

    // Output register slice plus grant FSM; all state reset asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full   <= 1'b0;
            data_o <= '0;
            last_o <= 1'b0;
            src_o  <= '0;
            state  <= IDLE;
            ptr    <= '0;
            owner  <= '0;
        end else begin
            if (wr_en) begin
                if (xfer_in) begin
                    full   <= 1'b1;
                    data_o <= beat_data;
                    last_o <= beat_last;
                    src_o  <= g;
                end else begin
                    full   <= 1'b0;
                end
            end
            if (xfer_in) begin
                if (beat_last) begin
                    state <= IDLE;
                    ptr   <= g + LW'(1);
                end else if (state == IDLE) begin
                    state <= LOCK;
                    owner <= g;
                end
            end
        end
    end

endmodule

// File: tb/tb_handshake_arb.sv
// Self-checking bench for handshake_arb: directed scenarios plus a randomized
// run compared against a transaction-level reference model.
module tb_handshake_arb;

    localparam int N  = 4;
    localparam int DW = 4;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [N-1:0]    req_valid_i = '0;
    logic [N*DW-1:0] req_data_i = '0;
    logic [N-1:0]    req_last_i = '0;
    logic [N-1:0]    req_ready_o;
    logic            valid_o;
    logic [DW-1:0]   data_o;
    logic            last_o;
    logic [1:0]      src_o;
    logic            ready_i = 1'b0;
    logic            busy_o;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_locked;
    int          m_owner;
    int          m_ptr;
    bit          m_full;
    int          m_data;
    bit          m_last;
    int          m_src;

    handshake_arb #(.N(N), .DW(DW)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
        .req_ready_o(req_ready_o),
        .valid_o(valid_o), .data_o(data_o), .last_o(last_o), .src_o(src_o),
        .ready_i(ready_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [N*DW-1:0] pack(input int d0, input int d1, input int d2, input int d3);
        logic [N*DW-1:0] v;
        v = '0;
        v[0*DW +: DW] = DW'(d0);
        v[1*DW +: DW] = DW'(d1);
        v[2*DW +: DW] = DW'(d2);
        v[3*DW +: DW] = DW'(d3);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        ready_i     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Model: who would the rules grant right now, given current inputs?
    function automatic int m_grant(input logic [N-1:0] v);
        if (m_locked) return m_owner;
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready(input logic [N-1:0] v, input logic rdy);
        int gi;
        logic [N-1:0] r;
        r  = '0;
        gi = m_grant(v);
        if (gi >= 0 && (!m_full || rdy)) r[gi] = 1'b1;
        return r;
    endfunction

    task automatic m_step(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                          input logic [N-1:0] l, input logic rdy);
        int  gi;
        bit  wen;
        bit  xin;
        gi  = m_grant(v);
        wen = !m_full || rdy;
        xin = (gi >= 0) && wen && v[gi];
        if (wen) begin
            if (xin) begin
                m_full = 1'b1;
                m_data = int'(d[gi*DW +: DW]);
                m_last = l[gi];
                m_src  = gi;
            end else begin
                m_full = 1'b0;
            end
        end
        if (xin) begin
            if (l[gi]) begin
                m_locked = 1'b0;
                m_ptr    = (gi + 1) % N;
            end else if (!m_locked) begin
                m_locked = 1'b1;
                m_owner  = gi;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req_valid_i = '0;
        ready_i = 1'b1;
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", valid_o); end
        checks++; if (data_o !== '0) begin errors++; $display("FAIL reset_data got %0h exp 0", data_o); end
        checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL reset_last got %0h exp 0", last_o); end
        checks++; if (src_o !== '0) begin errors++; $display("FAIL reset_src got %0h exp 0", src_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy_o); end
        checks++; if (req_ready_o !== '0) begin errors++; $display("FAIL reset_ready got %0h exp 0", req_ready_o); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid_i = 4'b1111;
        req_last_i  = 4'b1111;
        req_data_i  = pack(1, 2, 3, 4);
        ready_i     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (req_ready_o !== 4'(1 << (i % 4))) begin errors++; $display("FAIL rr_ready[%0d] got %0h exp %0h", i, req_ready_o, 4'(1 << (i % 4))); end
            tick();
            checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got %0h exp 1", i, valid_o); end
            checks++; if (src_o !== 2'(i % 4)) begin errors++; $display("FAIL rr_src[%0d] got %0h exp %0h", i, src_o, i % 4); end
            checks++; if (data_o !== 4'((i % 4) + 1)) begin errors++; $display("FAIL rr_data[%0d] got %0h exp %0h", i, data_o, (i % 4) + 1); end
            checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rr_busy[%0d] got %0h exp 0", i, busy_o); end
        end
        req_valid_i = '0;
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rr_drain got %0h exp 0", valid_o); end
    endtask

    task automatic test_burst();
        do_reset();
        ready_i = 1'b1;
        // single beat from requester 1 moves ptr to 2
        req_valid_i = 4'b0010;
        req_last_i  = 4'b0010;
        req_data_i  = pack(0, 1, 0, 0);
        tick();
        checks++; if (src_o !== 2'd1) begin errors++; $display("FAIL burst_pre_src got %0h exp 1", src_o); end
        for (int b = 0; b < 3; b++) begin
            req_valid_i = 4'b0101;
            req_last_i  = (b == 2) ? 4'b0101 : 4'b0001;
            req_data_i  = pack(10, 0, 5 + b, 0);
            #1;
            checks++; if (req_ready_o !== 4'b0100) begin errors++; $display("FAIL burst_ready[%0d] got %0h exp 4", b, req_ready_o); end
            tick();
            checks++; if (src_o !== 2'd2) begin errors++; $display("FAIL burst_src[%0d] got %0h exp 2", b, src_o); end
            checks++; if (data_o !== 4'(5 + b)) begin errors++; $display("FAIL burst_data[%0d] got %0h exp %0h", b, data_o, 5 + b); end
            checks++; if (busy_o !== (b != 2)) begin errors++; $display("FAIL burst_busy[%0d] got %0h exp %0h", b, busy_o, b != 2); end
        end
        checks++; if (last_o !== 1'b1) begin errors++; $display("FAIL burst_last got %0h exp 1", last_o); end
        req_valid_i = 4'b1001;
        #1;
        checks++; if (req_ready_o !== 4'b1000) begin errors++; $display("FAIL burst_ptr3 got %0h exp 8", req_ready_o); end
        req_valid_i = 4'b0101;
        req_last_i  = 4'b0101;
        #1;
        checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL burst_next_ready got %0h exp 1", req_ready_o); end
        tick();
        checks++; if (src_o !== 2'd0) begin errors++; $display("FAIL burst_next_src got %0h exp 0", src_o); end
    endtask

    task automatic test_gap();
        do_reset();
        ready_i = 1'b1;
        req_valid_i = 4'b0001;
        req_last_i  = 4'b0001;
        tick();
        req_valid_i = 4'b0010;
        req_last_i  = 4'b0000;
        req_data_i  = pack(0, 3, 0, 0);
        tick();
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL gap_lock got %0h exp 1", busy_o); end
        for (int c = 0; c < 2; c++) begin
            req_valid_i = 4'b1000;
            req_last_i  = 4'b1000;
            #1;
            checks++; if (req_ready_o[3] !== 1'b0) begin errors++; $display("FAIL gap_ready3[%0d] got %0h exp 0", c, req_ready_o[3]); end
            tick();
            checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL gap_valid[%0d] got %0h exp 0", c, valid_o); end
            checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL gap_busy[%0d] got %0h exp 1", c, busy_o); end
        end
        req_valid_i = 4'b1010;
        req_last_i  = 4'b1010;
        req_data_i  = pack(0, 4, 0, 12);
        #1;
        checks++; if (req_ready_o !== 4'b0010) begin errors++; $display("FAIL gap_resume_ready got %0h exp 2", req_ready_o); end
        tick();
        checks++; if (src_o !== 2'd1 || data_o !== 4'd4 || valid_o !== 1'b1) begin errors++; $display("FAIL gap_resume got src %0h data %0h exp src 1 data 4", src_o, data_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL gap_unlock got %0h exp 0", busy_o); end
    endtask

    task automatic test_backpressure();
        do_reset();
        ready_i = 1'b1;
        req_valid_i = 4'b0001;
        req_last_i  = 4'b0001;
        req_data_i  = pack(9, 0, 0, 0);
        tick();
        ready_i     = 1'b0;
        req_valid_i = 4'b0011;
        req_last_i  = 4'b0011;
        req_data_i  = pack(9, 2, 0, 0);
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got %0h exp 0", c, req_ready_o); end
            tick();
            checks++; if (valid_o !== 1'b1 || data_o !== 4'd9) begin errors++; $display("FAIL bp_hold[%0d] got valid %0h data %0h exp valid 1 data 9", c, valid_o, data_o); end
        end
        ready_i = 1'b1;
        #1;
        checks++; if (req_ready_o !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got %0h exp 2", req_ready_o); end
        tick();
        checks++; if (data_o !== 4'd2 || src_o !== 2'd1) begin errors++; $display("FAIL bp_next got data %0h src %0h exp data 2 src 1", data_o, src_o); end
    endtask

    task automatic test_async_reset();
        do_reset();
        ready_i = 1'b1;
        req_valid_i = 4'b0100;
        req_last_i  = 4'b0000;
        req_data_i  = pack(0, 0, 5, 0);
        tick();
        checks++; if (busy_o !== 1'b1 || src_o !== 2'd2) begin errors++; $display("FAIL ar_pre got busy %0h src %0h exp busy 1 src 2", busy_o, src_o); end
        #1 rstn = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0 || data_o !== '0 || src_o !== '0 || busy_o !== 1'b0 || last_o !== 1'b0) begin errors++; $display("FAIL ar_async got valid %0h data %0h src %0h busy %0h exp all 0", valid_o, data_o, src_o, busy_o); end
        tick();
        rstn = 1'b1;
        req_valid_i = 4'b0101;
        req_last_i  = 4'b0101;
        #1;
        checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL ar_after_ready got %0h exp 1", req_ready_o); end
        tick();
        checks++; if (src_o !== 2'd0) begin errors++; $display("FAIL ar_after_src got %0h exp 0", src_o); end
    endtask

    task automatic test_wrap();
        do_reset();
        ready_i = 1'b1;
        req_valid_i = 4'b1000;
        req_last_i  = 4'b1000;
        req_data_i  = pack(0, 0, 0, 12);
        #1;
        checks++; if (req_ready_o !== 4'b1000) begin errors++; $display("FAIL wrap_ready got %0h exp 8", req_ready_o); end
        tick();
        checks++; if (src_o !== 2'd3 || data_o !== 4'd12) begin errors++; $display("FAIL wrap_out got src %0h data %0h exp src 3 data c", src_o, data_o); end
        req_valid_i = 4'b1001;
        req_last_i  = 4'b1001;
        #1;
        checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL wrap_ptr0 got %0h exp 1", req_ready_o); end
    endtask

    task automatic test_random();
        logic [N-1:0]    v;
        logic [N-1:0]    l;
        logic [N*DW-1:0] d;
        logic            r;
        do_reset();
        m_locked = 0; m_owner = 0; m_ptr = 0; m_full = 0; m_data = 0; m_last = 0; m_src = 0;
        for (int c = 0; c < 400; c++) begin
            checks++; if (valid_o !== m_full) begin errors++; $display("FAIL rnd_valid[%0d] got %0h exp %0h", c, valid_o, m_full); end
            checks++; if (data_o !== 4'(m_data) || last_o !== m_last || src_o !== 2'(m_src)) begin errors++; $display("FAIL rnd_out[%0d] got d%0h l%0h s%0h exp d%0h l%0h s%0h", c, data_o, last_o, src_o, m_data, m_last, m_src); end
            checks++; if (busy_o !== m_locked) begin errors++; $display("FAIL rnd_busy[%0d] got %0h exp %0h", c, busy_o, m_locked); end
            for (int k = 0; k < N; k++) begin
                v[k] = ($urandom_range(0, 3) != 0);
                l[k] = ($urandom_range(0, 2) == 0);
            end
            d = N*DW'($urandom);
            r = ($urandom_range(0, 3) != 0);
            req_valid_i = v;
            req_last_i  = l;
            req_data_i  = d;
            ready_i     = r;
            #1;
            checks++; if (req_ready_o !== m_ready(v, r)) begin errors++; $display("FAIL rnd_ready[%0d] got %0h exp %0h", c, req_ready_o, m_ready(v, r)); end
            m_step(v, d, l, r);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst();
        test_gap();
        test_backpressure();
        test_async_reset();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
